// File: rtl/bitrev_sched_pkg.sv
// bitrev_pkg: shared constants for the bit-reverse scheduler slice.
//   ST_IDLE / ST_FULL : result-register state encoding
//   DEF_N, DEF_NREQ, DEF_CNTW : default word width, requester count, counter width
//   idw_calc() : requester-ID width, at least one bit even for a single requester
package bitrev_pkg;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_FULL = 1'b1;

    localparam int unsigned DEF_N    = 8;
    localparam int unsigned DEF_NREQ = 4;
    localparam int unsigned DEF_CNTW = 16;

    function automatic int unsigned idw_calc(input int unsigned nreq);
        return (nreq > 1) ? $clog2(nreq) : 1;
    endfunction

endpackage

// File: rtl/bitrev_sched_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick among NREQ requesters.
//   req    : per-requester request lines
//   ptr    : highest-priority index (held by the parent)
//   enable : when low, no grant is issued (idx still reports the winner)
//   grant  : one-hot grant
//   idx    : encoded index of the winning requester
module rr_arbiter
    import bitrev_pkg::*;
#(
    parameter int unsigned NREQ = DEF_NREQ,
    localparam int unsigned IDW = idw_calc(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    input  logic            enable,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  idx
);

    logic        found;
    int unsigned pos;

    // Walk positions ptr, ptr+1, ... (mod NREQ); the inner loop maps the
    // rotating position back onto a constant index so every select is static.
    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        pos   = 0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            pos = 32'(ptr) + i;
            if (pos >= NREQ) begin
                pos = pos - NREQ;
            end
            for (int unsigned k = 0; k < NREQ; k++) begin
                if (!found && (k == pos) && req[k]) begin
                    found    = 1'b1;
                    idx      = IDW'(k);
                    grant[k] = enable;
                end
            end
        end
    end

endmodule

// File: rtl/bitrev_sched.sv
// bitrev_sched: round-robin scheduler sharing one bit-reverse/palindrome
// datapath among NREQ requesters, with a registered valid/ready result port.
//   clk, rst_n           : clock, asynchronous active-low reset
//   req_valid/req_data   : per-requester valid and packed N-bit words
//   req_ready            : one-hot accept strobe
//   out_valid/out_ready  : result handshake
//   out_rev/out_palind   : reversed word and palindrome flag
//   out_id               : index of the requester that supplied the word
//   clr_count/pal_count  : synchronous clear / saturating palindrome count
module bitrev_sched
    import bitrev_pkg::*;
#(
    parameter int unsigned N    = DEF_N,
    parameter int unsigned NREQ = DEF_NREQ,
    parameter int unsigned CNTW = DEF_CNTW,
    localparam int unsigned IDW = idw_calc(NREQ)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NREQ-1:0]     req_valid,
    input  logic [NREQ*N-1:0]   req_data,
    output logic [NREQ-1:0]     req_ready,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [N-1:0]        out_rev,
    output logic                out_palind,
    output logic [IDW-1:0]      out_id,
    input  logic                clr_count,
    output logic [CNTW-1:0]     pal_count
);

    function automatic logic [N-1:0] bit_reverse(input logic [N-1:0] w);
        logic [N-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < N; i++) begin
            r[N-1-i] = w[i];
        end
        return r;
    endfunction

    logic [0:0]      state;
    logic [IDW-1:0]  ptr;
    logic            can_accept;
    logic            accept;
    logic            handshake;
    logic [NREQ-1:0] grant;
    logic [IDW-1:0]  grant_idx;
    logic [N-1:0]    sel_word;
    logic [N-1:0]    sel_rev;
    logic            sel_pal;

    assign out_valid  = (state == ST_FULL);
    assign handshake  = out_valid && out_ready;
    // Gating with rst_n keeps req_ready low for the whole reset period.
    assign can_accept = rst_n && ((state == ST_IDLE) || handshake);

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_arb (
        .req    (req_valid),
        .ptr    (ptr),
        .enable (can_accept),
        .grant  (grant),
        .idx    (grant_idx)
    );

    assign req_ready = grant;
    assign accept    = |grant;

    always_comb begin
        sel_word = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (32'(grant_idx) == k) begin
                sel_word = req_data[k*N +: N];
            end
        end
    end

    assign sel_rev = bit_reverse(sel_word);
    assign sel_pal = (sel_word == sel_rev);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            ptr        <= '0;
            out_rev    <= '0;
            out_palind <= 1'b0;
            out_id     <= '0;
        end else if (accept) begin
            state      <= ST_FULL;
            out_rev    <= sel_rev;
            out_palind <= sel_pal;
            out_id     <= grant_idx;
            if (32'(grant_idx) == NREQ - 1) begin
                ptr <= '0;
            end else begin
                ptr <= grant_idx + 1'b1;
            end
        end else if (handshake) begin
            state <= ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pal_count <= '0;
        end else if (clr_count) begin
            pal_count <= '0;
        end else if (handshake && out_palind && (pal_count != '1)) begin
            pal_count <= pal_count + 1'b1;
        end
    end

endmodule
